binary_threshold_filter: RTL and testbench

Row-parallel binary thresholding stage for the image-processing pipeline. Each clock it takes one full image row of packed 24-bit RGB pixels and converts every pixel to pure black or pure white. The decision compares the pixel's integer luminance against a fixed threshold. The registered result row feeds the downstream row writer or filter stage.

---
 rtl/binary_threshold_filter.sv | 66 ++++++
 tb/tb_binary_threshold_filter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/binary_threshold_filter.sv
// binary_threshold_filter
//   Row-parallel binary threshold stage. Every pixel of a packed RGB row is
//   reduced to integer luminance Y = (77*R + 150*G + 29*B) >> 8 and replaced
//   by pure white (all ones) when Y >= THRESHOLD, otherwise pure black.
//   The binarized row is registered once; there is no other state.
//
// Parameters
//   ROW       pixels per row
//   WIDTH     bits per colour channel
//   THRESHOLD luminance threshold, 0 .. 2**WIDTH-1
//
// Ports
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset, clears row_out
//   SET      row-load enable; row_out takes the binarized row_in on CLK
//   row_in   packed input row, pixel k at [3*WIDTH*k +: 3*WIDTH], R,G,B high to low
//   row_out  registered binarized row, same packing
module binary_threshold_filter #(
  parameter int unsigned ROW       = 256,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SET,
  input  logic [ROW*WIDTH*3-1:0]   row_in,
  output logic [ROW*WIDTH*3-1:0]   row_out
);

  localparam int unsigned PIX  = 3 * WIDTH;
  // Weighted sum peaks at 256*(2**WIDTH-1); WIDTH+9 bits covers it with margin.
  localparam int unsigned SUMW = WIDTH + 9;

  // floor(sum/256) >= T is the same as sum >= 256*T, so the compare runs on
  // the full weighted sum and the shift disappears.
  localparam logic [SUMW-1:0] THR_SCALED = SUMW'(THRESHOLD) << 8;

  logic [ROW*PIX-1:0] binarized;

  for (genvar k = 0; k < ROW; k++) begin : g_pix
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
    logic [SUMW-1:0]  sum;
    logic             white;

    assign r     = row_in[k*PIX + 2*WIDTH +: WIDTH];
    assign g     = row_in[k*PIX +   WIDTH +: WIDTH];
    assign b     = row_in[k*PIX            +: WIDTH];
    assign sum   = SUMW'(77)  * SUMW'(r)
                 + SUMW'(150) * SUMW'(g)
                 + SUMW'(29)  * SUMW'(b);
    assign white = (sum >= THR_SCALED);

    assign binarized[k*PIX +: PIX] = {PIX{white}};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_out <= '0;
    end else if (SET) begin
      row_out <= binarized;
    end
  end

endmodule

// File: tb/tb_binary_threshold_filter.sv
// tb_binary_threshold_filter
//   Directed bench for binary_threshold_filter with default parameters.
//   Covers reset behaviour, the luminance threshold boundary, individual
//   channel weights, pixel packing order, hold with SET low, mid-stream
//   reset and back-to-back streaming against a luminance model.
module tb_binary_threshold_filter;

  localparam int unsigned ROW       = 256;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned THRESHOLD = 128;
  localparam int unsigned PIX       = 3 * WIDTH;
  localparam int unsigned N         = ROW * PIX;

  logic         CLK = 1'b0;
  logic         RST;
  logic         SET;
  logic [N-1:0] row_in;
  logic [N-1:0] row_out;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  binary_threshold_filter #(
    .ROW       (ROW),
    .WIDTH     (WIDTH),
    .THRESHOLD (THRESHOLD)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SET     (SET),
    .row_in  (row_in),
    .row_out (row_out)
  );

  function automatic logic [N-1:0] fill(input logic [PIX-1:0] p);
    logic [N-1:0] r;
    for (int k = 0; k < ROW; k++) r[k*PIX +: PIX] = p;
    return r;
  endfunction

  // Reference binarization straight from the luminance formula.
  function automatic logic [N-1:0] model(input logic [N-1:0] src);
    logic [N-1:0] r;
    int unsigned  y;
    for (int k = 0; k < ROW; k++) begin
      y = (77  * int'(src[k*PIX + 16 +: 8]) +
           150 * int'(src[k*PIX +  8 +: 8]) +
           29  * int'(src[k*PIX      +: 8])) >> 8;
      r[k*PIX +: PIX] = (y >= THRESHOLD) ? 24'hFFFFFF : 24'h000000;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_row();
    logic [N-1:0] r;
    for (int k = 0; k < ROW; k++) r[k*PIX +: PIX] = PIX'($urandom);
    return r;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    int first;
    checks++;
    if (got !== exp) begin
      errors++;
      first = 0;
      for (int k = ROW - 1; k >= 0; k--)
        if (got[k*PIX +: PIX] !== exp[k*PIX +: PIX]) first = k;
      $display("FAIL %s pixel %0d got %06h exp %06h", tag, first,
               got[first*PIX +: PIX], exp[first*PIX +: PIX]);
    end
  endtask

  task automatic load(input logic [N-1:0] r);
    @(negedge CLK);
    row_in = r;
    SET    = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  logic [PIX-1:0] dir_in  [6] = '{24'h808080, 24'h7F7F7F, 24'hFF0000,
                                  24'h00FF00, 24'h0000FF, 24'hFFFFFF};
  logic [PIX-1:0] dir_exp [6] = '{24'hFFFFFF, 24'h000000, 24'h000000,
                                  24'hFFFFFF, 24'h000000, 24'hFFFFFF};

  initial begin
    logic [N-1:0] pat_in, pat_exp, a, b, cur;

    RST    = 1'b1;
    SET    = 1'b0;
    row_in = '0;
    #2;
    check("reset_state", row_out, '0);
    @(negedge CLK);
    RST = 1'b0;

    // Load white, then reset between edges: output must clear at once.
    load(fill(24'hFFFFFF));
    check("pre_reset_white", row_out, fill(24'hFFFFFF));
    #2;
    RST = 1'b1;
    #1;
    check("async_reset", row_out, '0);
    row_in = fill(24'hFFFFFF);
    SET    = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hold", row_out, '0);
    @(negedge CLK);
    RST = 1'b0;
    SET = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load(fill(dir_in[i]));
      check($sformatf("directed_%06h", dir_in[i]), row_out, fill(dir_exp[i]));
    end

    // Alternating black/white with distinct end pixels.
    for (int k = 0; k < ROW; k++) begin
      pat_in [k*PIX +: PIX] = (k % 2) ? 24'hFFFFFF : 24'h000000;
      pat_exp[k*PIX +: PIX] = (k % 2) ? 24'hFFFFFF : 24'h000000;
    end
    pat_in [0 +: PIX]           = 24'h00FF00;
    pat_exp[0 +: PIX]           = 24'hFFFFFF;
    pat_in [(ROW-1)*PIX +: PIX] = 24'h0000FF;
    pat_exp[(ROW-1)*PIX +: PIX] = 24'h000000;
    load(pat_in);
    check("packing", row_out, pat_exp);

    // Hold: SET low, row_in changes, output keeps binarized A.
    a = fill(24'h808080);
    b = pat_in;
    load(a);
    check("hold_load_a", row_out, fill(24'hFFFFFF));
    @(negedge CLK);
    SET    = 1'b0;
    row_in = b;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      check($sformatf("hold_cycle%0d", c), row_out, fill(24'hFFFFFF));
    end
    load(b);
    check("hold_load_b", row_out, pat_exp);

    // Back-to-back streaming, one new row per edge.
    for (int i = 0; i < 256; i++) begin
      cur = rand_row();
      cur[0 +: 16] = 16'(i);
      load(cur);
      check($sformatf("stream_%0d", i), row_out, model(cur));
    end

    // Mid-stream reset discards the row in flight; first SET edge after is valid.
    #2;
    RST    = 1'b1;
    row_in = fill(24'hFFFFFF);
    #1;
    check("midstream_reset", row_out, '0);
    @(posedge CLK);
    #1;
    check("midstream_reset_edge", row_out, '0);
    @(negedge CLK);
    RST = 1'b0;
    load(fill(24'h00FF00));
    check("post_reset_load", row_out, fill(24'hFFFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
